// File: rtl/addr_seq_pkg.sv
// Shared types for the programmable MSS address sequencer.
// Widths, sweep modes, FSM states and the shadow config bundle.
package addr_seq_pkg;

  localparam int SEQ_ADDR_W   = 8;
  localparam int SEQ_STRIDE_W = 4;
  localparam int SEQ_PASS_W   = 8;

  typedef enum logic [1:0] {
    WRAP     = 2'd0,
    ONESHOT  = 2'd1,
    PINGPONG = 2'd2,
    RSVD     = 2'd3
  } addr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [SEQ_ADDR_W-1:0]   base;
    logic [SEQ_ADDR_W-1:0]   limit;
    logic [SEQ_STRIDE_W-1:0] stride;
    addr_mode_e              mode;
  } seq_cfg_t;

  function automatic logic cfg_bad(seq_cfg_t c);
    return (c.base > c.limit) || (c.stride == '0) || (c.mode == RSVD);
  endfunction

endpackage

// File: rtl/addr_seq_step.sv
// Combinational next-address / turnaround calculation.
// Overflow is judged in ADDR_W+1 bits so the sweep never wraps mod 2**ADDR_W.
module addr_seq_step
  import addr_seq_pkg::*;
(
  input  logic [SEQ_ADDR_W-1:0] addr,
  input  logic                  dir_dn,
  input  seq_cfg_t              cfg,
  output logic [SEQ_ADDR_W-1:0] nxt_addr,
  output logic                  nxt_dn,
  output logic                  wrapped,
  output logic                  finished
);

  localparam int W1 = SEQ_ADDR_W + 1;

  logic [SEQ_ADDR_W-1:0] str_a;
  logic [SEQ_ADDR_W-1:0] up_a;
  logic [SEQ_ADDR_W-1:0] dn_a;
  logic [W1-1:0]         up_x;
  logic [W1-1:0]         floor_x;
  logic                  over;
  logic                  under;

  assign str_a   = {{(SEQ_ADDR_W-SEQ_STRIDE_W){1'b0}}, cfg.stride};
  assign up_a    = addr + str_a;
  assign dn_a    = addr - str_a;
  assign up_x    = {1'b0, addr} + {1'b0, str_a};
  assign floor_x = {1'b0, cfg.base} + {1'b0, str_a};
  assign over    = up_x > {1'b0, cfg.limit};
  // under: stepping down would cross below base
  assign under   = {1'b0, addr} < floor_x;

  always_comb begin
    nxt_addr = addr;
    nxt_dn   = dir_dn;
    wrapped  = 1'b0;
    finished = 1'b0;
    case (cfg.mode)
      WRAP: begin
        if (over) begin
          nxt_addr = cfg.base;
          wrapped  = 1'b1;
        end else begin
          nxt_addr = up_a;
        end
      end
      ONESHOT: begin
        if (over) finished = 1'b1;
        else      nxt_addr = up_a;
      end
      PINGPONG: begin
        if (!dir_dn) begin
          if (over) begin
            nxt_dn   = 1'b1;
            wrapped  = 1'b1;
            nxt_addr = under ? cfg.base : dn_a;
          end else begin
            nxt_addr = up_a;
          end
        end else begin
          if (under) begin
            nxt_dn   = 1'b0;
            wrapped  = 1'b1;
            nxt_addr = over ? cfg.limit : up_a;
          end else begin
            nxt_addr = dn_a;
          end
        end
      end
      default: begin
        nxt_addr = addr;
      end
    endcase
  end

endmodule

// File: rtl/addr_sequencer.sv
// Programmable address sweep generator: wrap / one-shot / ping-pong.
// Define ADDR_SEQ_PASS_CNT_EN to build the saturating pass counter.
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W   = SEQ_ADDR_W,
  parameter int STRIDE_W = SEQ_STRIDE_W,
  parameter int PASS_W   = SEQ_PASS_W
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                cfg_load,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_limit,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic [1:0]          cfg_mode,
  input  logic                start,
  input  logic                stop,
  input  logic                en,
  input  logic                en1,
  input  logic                addr_ready,
  output logic [ADDR_W-1:0]   addr,
  output logic                addr_valid,
  output logic                busy,
  output logic                wrap_pulse,
  output logic                done,
  output logic                cfg_err,
  output logic [PASS_W-1:0]   pass_cnt
);

  seq_state_e state_q, state_d;
  seq_cfg_t   cfg_q, cfg_d, cfg_in, cfg_use;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic wrap_q, wrap_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic dir_q, dir_d;
  logic beat;

  logic [ADDR_W-1:0] step_addr;
  logic step_dn, step_wrap, step_fin;

  assign cfg_in = '{base:   cfg_base,
                    limit:  cfg_limit,
                    stride: cfg_stride,
                    mode:   addr_mode_e'(cfg_mode)};

  assign beat = (state_q == RUN) && valid_q && addr_ready && en && en1;

  addr_seq_step u_step (
    .addr     (addr_q),
    .dir_dn   (dir_q),
    .cfg      (cfg_q),
    .nxt_addr (step_addr),
    .nxt_dn   (step_dn),
    .wrapped  (step_wrap),
    .finished (step_fin)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cfg_use = cfg_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    done_d  = done_q;
    err_d   = 1'b0;
    dir_d   = dir_q;
    // a load in the start cycle is what that start sweeps with
    if (cfg_load && state_q != RUN) begin
      cfg_d   = cfg_in;
      cfg_use = cfg_in;
      done_d  = 1'b0;
    end
    case (state_q)
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (beat) begin
          addr_d = step_addr;
          dir_d  = step_dn;
          wrap_d = step_wrap;
          if (step_fin) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          if (cfg_bad(cfg_use)) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            addr_d  = cfg_use.base;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            dir_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cfg_q   <= '{base: '0, limit: '1, stride: 4'd1, mode: WRAP};
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
    end
  end

`ifdef ADDR_SEQ_PASS_CNT_EN
  logic [PASS_W-1:0] pass_q, pass_d;

  always_comb begin
    pass_d = pass_q;
    if (state_q != RUN && start && !cfg_bad(cfg_use)) begin
      pass_d = '0;
    end else if (state_q == RUN && !stop && beat &&
                 (step_wrap || step_fin) && pass_q != '1) begin
      pass_d = pass_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) pass_q <= '0;
    else       pass_q <= pass_d;
  end

  assign pass_cnt = pass_q;
`else
  assign pass_cnt = '0;
`endif

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign wrap_pulse = wrap_q;
  assign done       = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed table-driven bench for addr_sequencer.
// Build with ADDR_SEQ_PASS_CNT_EN to also exercise the pass counter.
module tb_addr_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_base = '0;
  logic [7:0] cfg_limit = '0;
  logic [3:0] cfg_stride = '0;
  logic [1:0] cfg_mode = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic       en1 = 1'b0;
  logic       addr_ready = 1'b0;
  logic [7:0] addr;
  logic       addr_valid, busy, wrap_pulse, done, cfg_err;
  logic [7:0] pass_cnt;

  int nchk = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  addr_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .cfg_load   (cfg_load),
    .cfg_base   (cfg_base),
    .cfg_limit  (cfg_limit),
    .cfg_stride (cfg_stride),
    .cfg_mode   (cfg_mode),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .en1        (en1),
    .addr_ready (addr_ready),
    .addr       (addr),
    .addr_valid (addr_valid),
    .busy       (busy),
    .wrap_pulse (wrap_pulse),
    .done       (done),
    .cfg_err    (cfg_err),
    .pass_cnt   (pass_cnt)
  );

  typedef struct {
    int ld, b, l, s, m;
    int st, sp, r, e, e1;
    int ea, ev, eb, ew, ed, ee;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int ld, int b, int l, int s, int m,
                              int st, int sp, int r, int e, int e1,
                              int ea, int ev, int eb, int ew, int ed,
                              int ee);
    vec_t v;
    v.ld = ld; v.b = b; v.l = l; v.s = s; v.m = m;
    v.st = st; v.sp = sp; v.r = r; v.e = e; v.e1 = e1;
    v.ea = ea; v.ev = ev; v.eb = eb; v.ew = ew; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cfg_load   = v.ld[0];
    cfg_base   = 8'(v.b);
    cfg_limit  = 8'(v.l);
    cfg_stride = 4'(v.s);
    cfg_mode   = 2'(v.m);
    start      = v.st[0];
    stop       = v.sp[0];
    addr_ready = v.r[0];
    en         = v.e[0];
    en1        = v.e1[0];
  endtask

  function automatic logic [12:0] outs();
    return {addr, addr_valid, busy, wrap_pulse, done, cfg_err};
  endfunction

  function automatic logic [12:0] expv(vec_t v);
    return {8'(v.ea), v.ev[0], v.eb[0], v.ew[0], v.ed[0], v.ee[0]};
  endfunction

  vec_t idle_v, beat_v;
  int   wraps;
  int   exp_pass;

  initial begin
    idle_v = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0);
    beat_v = mk(0,0,0,0,0, 0,0,1,1,1, 0,0,0,0,0,0);

    // WRAP 10..20 step 3, then enable/ready holds, stop with a beat
    tv.push_back(mk(1,10,20,3,0, 1,0,0,0,0, 10,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 13,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 16,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 19,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 10,1,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 13,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,0,1, 13,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,0, 13,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,1,1, 13,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,1,1,1, 13,0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,0,0,0, 13,0,0,0,0,0));
    // ONESHOT
    tv.push_back(mk(1,10,20,3,1, 1,0,0,0,0, 10,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 13,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 16,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 19,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 19,0,0,0,1,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 19,0,0,0,1,0));
    // PINGPONG, start and stop together: start wins
    tv.push_back(mk(1,10,20,3,2, 1,1,0,0,0, 10,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 13,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 16,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 19,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 16,1,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 13,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 10,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 13,1,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 16,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,0,0,0, 16,0,0,0,0,0));
    // rejected starts: base>limit, stride 0, reserved mode
    tv.push_back(mk(1,30,20,3,0, 1,0,0,0,0, 16,0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 16,0,0,0,0,0));
    tv.push_back(mk(1,10,20,0,0, 1,0,0,0,0, 16,0,0,0,0,1));
    tv.push_back(mk(1,10,20,3,3, 1,0,0,0,0, 16,0,0,0,0,1));
    // single-address ping-pong range
    tv.push_back(mk(1,5,5,2,2, 1,0,0,0,0, 5,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 5,1,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 5,1,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,1,1,1, 5,0,0,0,0,0));
    // limit at top of address space: no modulo wrap
    tv.push_back(mk(1,250,255,4,0, 1,0,0,0,0, 250,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 254,1,1,0,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,1,1, 250,1,1,1,0,0));
    tv.push_back(mk(0,0,0,0,0, 0,1,0,0,0, 250,0,0,0,0,0));

    // reset state
    tick();
    tick();
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_pass", 32'(pass_cnt), 32'd0);
    RESET = 1'b0;

    // full-range wrap from reset defaults
    start = 1'b1;
    tick();
    start = 1'b0;
    addr_ready = 1'b1; en = 1'b1; en1 = 1'b1;
    chk("full_first", 32'({addr, addr_valid, busy}), 32'({8'd0, 2'b11}));
    for (int i = 1; i < 260; i++) begin
      tick();
      chk($sformatf("full_%0d", i), 32'({addr, wrap_pulse}),
          32'({8'(i % 256), (i == 256) ? 1'b1 : 1'b0}));
    end
`ifdef ADDR_SEQ_PASS_CNT_EN
    exp_pass = 1;
`else
    exp_pass = 0;
`endif
    chk("full_pass", 32'(pass_cnt), 32'(exp_pass));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("full_stop", 32'({addr_valid, busy}), 32'd0);

    foreach (tv[i]) begin
      drive(tv[i]);
      tick();
      chk($sformatf("vec_%0d", i), 32'(outs()), 32'(expv(tv[i])));
    end
    drive(idle_v);

    // reset in the middle of a sweep
    drive(mk(1,10,20,3,0, 1,0,0,0,0, 0,0,0,0,0,0));
    tick();
    drive(beat_v);
    tick();
    tick();
    chk("mid_run", 32'(addr), 32'd16);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_mid_outs", 32'(outs()), 32'd0);
    chk("rst_mid_pass", 32'(pass_cnt), 32'd0);
    drive(mk(0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,0,0));
    tick();
    drive(idle_v);
    chk("rst_cfg_dflt", 32'({addr, addr_valid}), 32'({8'd0, 1'b1}));
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // eight WRAP passes over 10..20 step 3
    drive(mk(1,10,20,3,0, 1,0,0,0,0, 0,0,0,0,0,0));
    tick();
    drive(beat_v);
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (wrap_pulse) wraps++;
    end
    chk("pass_wraps", 32'(wraps), 32'd8);
`ifdef ADDR_SEQ_PASS_CNT_EN
    exp_pass = 8;
`else
    exp_pass = 0;
`endif
    chk("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    chk("pass_addr", 32'(addr), 32'd10);
    drive(idle_v);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
